// File: rtl/dmem_unit.sv
// dmem_unit: data-memory stage endpoint. Word RAM with byte/half access and aligned, extended loads, plus a
// 64-byte MMIO window (LED, SW, CYCLE, TX, STATUS). Define DMEM_TXFIFO_EN to build the TX FIFO.
module dmem_unit #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_w,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  dm_type,
  output logic [31:0] rdata,
  input  logic [15:0] sw,
  output logic [15:0] led,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        misalign
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  localparam logic [3:0] OFF_LED    = 4'h0;
  localparam logic [3:0] OFF_SW     = 4'h1;
  localparam logic [3:0] OFF_CYCLE  = 4'h2;
  localparam logic [3:0] OFF_TX     = 4'h3;
  localparam logic [3:0] OFF_STATUS = 4'h4;

  typedef enum logic [1:0] {SZ_WORD, SZ_HALF, SZ_BYTE} size_e;

  // ---------------------------------------------------------------------------
  // Access decode
  // ---------------------------------------------------------------------------
  size_e w_size;
  logic  w_signed;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can leave it unassigned and infer a latch.
    w_size   = SZ_WORD;
    w_signed = 1'b0;
    case (dm_type)
      3'b001: begin w_size = SZ_HALF; w_signed = 1'b1; end
      3'b010: begin w_size = SZ_HALF; w_signed = 1'b0; end
      3'b011: begin w_size = SZ_BYTE; w_signed = 1'b1; end
      3'b100: begin w_size = SZ_BYTE; w_signed = 1'b0; end
      default: ;
    endcase
  end

  logic       w_misaligned;
  logic       w_is_mmio;
  logic       w_mmio_ok;
  logic [3:0] w_reg;
  logic       w_wr_en;
  logic       w_ram_we;
  logic       w_mmio_we;
  logic       w_led_we;
  logic       w_status_clr;

  assign w_misaligned = ((w_size == SZ_WORD) && (addr[1:0] != 2'b00)) ||
                        ((w_size == SZ_HALF) && addr[0]);
  assign w_is_mmio    = (addr[31:6] == MMIO_BASE[31:6]);
  assign w_mmio_ok    = w_is_mmio && (w_size == SZ_WORD) && !w_misaligned;
  assign w_reg        = addr[5:2];

  // A store in a reset cycle or a misaligned store never reaches RAM or registers.
  assign w_wr_en      = mem_w && !rst && !w_misaligned;
  assign w_ram_we     = w_wr_en && !w_is_mmio;
  assign w_mmio_we    = w_wr_en && w_mmio_ok;
  assign w_led_we     = w_mmio_we && (w_reg == OFF_LED);
  assign w_status_clr = w_mmio_we && (w_reg == OFF_STATUS) && wdata[10];

  // ---------------------------------------------------------------------------
  // RAM
  // ---------------------------------------------------------------------------
  logic [AW-1:0] w_idx;
  logic [3:0]    w_be;
  logic [31:0]   w_wlane;

  assign w_idx = addr[AW+1:2];

  always_comb begin
    w_be    = 4'b1111;
    w_wlane = wdata;
    case (w_size)
      SZ_HALF: begin
        w_be    = addr[1] ? 4'b1100 : 4'b0011;
        w_wlane = {2{wdata[15:0]}};
      end
      SZ_BYTE: begin
        w_be    = 4'b0001 << addr[1:0];
        w_wlane = {4{wdata[7:0]}};
      end
      default: ;
    endcase
  end

  logic [31:0] r_mem [DEPTH_WORDS];

  // NOTE: RAM contents have no reset so the array maps onto plain memory; software must initialise what it reads.
  // NOTE: clocked state is always assigned with <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wlane[8*b +: 8];
      end
    end
  end

  logic [31:0] w_word;
  logic [15:0] w_half;
  logic [7:0]  w_byte;
  logic [31:0] w_ram_rd;

  assign w_word = r_mem[w_idx];
  assign w_half = addr[1] ? w_word[31:16] : w_word[15:0];
  assign w_byte = w_word[{addr[1:0], 3'b000} +: 8];

  always_comb begin
    w_ram_rd = w_word;
    case (w_size)
      SZ_HALF: w_ram_rd = {{16{w_signed & w_half[15]}}, w_half};
      SZ_BYTE: w_ram_rd = {{24{w_signed & w_byte[7]}}, w_byte};
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // MMIO registers
  // ---------------------------------------------------------------------------
  logic [15:0] r_led;
  logic [31:0] r_cycle;
  logic        r_misalign;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_led      <= '0;
      r_cycle    <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (w_led_we) r_led <= wdata[15:0];
      // A new misaligned access outranks a same-cycle clear.
      if (w_misaligned)      r_misalign <= 1'b1;
      else if (w_status_clr) r_misalign <= 1'b0;
    end
  end

  assign led      = r_led;
  assign misalign = r_misalign;

  logic [7:0] w_count8;
  logic       w_empty;
  logic       w_full;

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
`ifdef DMEM_TXFIFO_EN
  localparam int unsigned FW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = FW + 1;

  logic [7:0]    r_fifo [FIFO_DEPTH];
  logic [FW-1:0] r_wr_ptr;
  logic [FW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_tx_we;
  logic          w_push;
  logic          w_pop;

  assign w_tx_we  = w_mmio_we && (w_reg == OFF_TX);
  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CW'(FIFO_DEPTH));
  assign w_pop    = !w_empty && tx_ready;
  // A pop in the same cycle frees the slot, so a push to a full FIFO is still accepted.
  assign w_push   = w_tx_we && (!w_full || w_pop);
  assign w_count8 = 8'(r_count);

  assign tx_valid = !w_empty;
  assign tx_data  = w_empty ? 8'h00 : r_fifo[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + FW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + FW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end
`else
  logic w_unused_tx;

  assign tx_valid    = 1'b0;
  assign tx_data     = 8'h00;
  assign w_empty     = 1'b1;
  assign w_full      = 1'b0;
  assign w_count8    = 8'h00;
  assign w_unused_tx = tx_ready & (FIFO_DEPTH != 0);
`endif

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  logic [31:0] w_mmio_rd;

  always_comb begin
    w_mmio_rd = '0;
    if (w_mmio_ok) begin
      case (w_reg)
        OFF_LED:    w_mmio_rd = {16'h0000, r_led};
        OFF_SW:     w_mmio_rd = {16'h0000, sw};
        OFF_CYCLE:  w_mmio_rd = r_cycle;
        OFF_TX:     w_mmio_rd = '0;
        OFF_STATUS: w_mmio_rd = {21'h0, r_misalign, w_full, w_empty, w_count8};
        default:    w_mmio_rd = '0;
      endcase
    end
  end

  assign rdata = w_misaligned ? '0 : (w_is_mmio ? w_mmio_rd : w_ram_rd);

endmodule

// File: tb/tb_dmem_unit.sv
// tb_dmem_unit: table-driven vectors and directed corner sequences for dmem_unit, then randomized traffic
// compared every cycle against a byte-array / queue reference model.
module tb_dmem_unit;

  localparam logic [31:0] MB     = 32'hFFFF_0000;
  localparam int          FDEPTH = 8;
`ifdef DMEM_TXFIFO_EN
  localparam bit FIFO_EN = 1'b1;
`else
  localparam bit FIFO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_w;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  dm_type;
  logic [31:0] rdata;
  logic [15:0] sw;
  logic [15:0] led;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        misalign;

  int n_chk = 0;
  int n_err = 0;

  dmem_unit dut (
    .clk(clk), .rst(rst), .mem_w(mem_w), .addr(addr), .wdata(wdata), .dm_type(dm_type),
    .rdata(rdata), .sw(sw), .led(led), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .misalign(misalign)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0]  m_mem [4096];
  logic [15:0] m_led;
  logic [31:0] m_cycle;
  bit          m_mis;
  logic [7:0]  m_q [$];

  function automatic int size_of(input logic [2:0] t);
    case (t)
      3'd1, 3'd2: return 2;
      3'd3, 3'd4: return 1;
      default:    return 4;
    endcase
  endfunction

  function automatic bit is_mmio(input logic [31:0] a);
    logic [31:0] d;
    d = a - MB;
    return d < 32'd64;
  endfunction

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = 32'(m_q.size());
    if (m_q.size() == 0)      s = s | 32'h100;
    if (m_q.size() == FDEPTH) s = s | 32'h200;
    if (m_mis)                s = s | 32'h400;
    return s;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic [2:0] t);
    int          sz;
    logic [31:0] v;
    sz = size_of(t);
    v  = '0;
    if ((a % sz) != 0) return '0;
    if (is_mmio(a)) begin
      if (sz != 4) return '0;
      case (a - MB)
        32'd0:   return {16'h0, m_led};
        32'd4:   return {16'h0, sw};
        32'd8:   return m_cycle;
        32'd16:  return model_status();
        default: return '0;
      endcase
    end
    for (int i = 0; i < sz; i++) v = v | (32'(m_mem[(a + 32'(i)) % 4096]) << (8 * i));
    if ((t == 3'd1 || t == 3'd3) && v[8*sz-1]) v = v - (32'd1 << (8 * sz));
    return v;
  endfunction

  function automatic void model_step();
    int sz;
    bit mis, pop, push, clr;
    sz = size_of(dm_type);
    if (rst) begin
      m_led = '0; m_cycle = '0; m_mis = 1'b0; m_q.delete();
      return;
    end
    mis  = (addr % sz) != 0;
    pop  = FIFO_EN && (m_q.size() > 0) && tx_ready;
    push = 1'b0;
    clr  = 1'b0;
    if (mem_w && !mis) begin
      if (is_mmio(addr)) begin
        if (sz == 4) begin
          case (addr - MB)
            32'd0:   m_led = wdata[15:0];
            32'd12:  push = FIFO_EN;
            32'd16:  clr = wdata[10];
            default: ;
          endcase
        end
      end else begin
        for (int i = 0; i < sz; i++) m_mem[(addr + 32'(i)) % 4096] = wdata[8*i +: 8];
      end
    end
    if (mis)      m_mis = 1'b1;
    else if (clr) m_mis = 1'b0;
    if (pop) void'(m_q.pop_front());
    if (push && m_q.size() < FDEPTH) m_q.push_back(wdata[7:0]);
    m_cycle = m_cycle + 32'd1;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic put(input logic mw, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] t);
    mem_w = mw; addr = a; wdata = wd; dm_type = t;
    #1;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp_model();
    check("rnd_rdata",    rdata,               model_read(addr, dm_type));
    check("rnd_led",      {16'h0, led},        {16'h0, m_led});
    check("rnd_misalign", {31'h0, misalign},   {31'h0, m_mis});
    check("rnd_tx_valid", {31'h0, tx_valid},   32'(m_q.size() != 0));
    check("rnd_tx_data",  {24'h0, tx_data},    (m_q.size() != 0) ? {24'h0, m_q[0]} : 32'h0);
  endtask

  typedef struct {
    string       name;
    logic        mw;
    logic [31:0] a;
    logic [31:0] wd;
    logic [2:0]  t;
    bit          chk;
    logic [31:0] exp;
  } vec_t;

  function automatic vec_t mk(input string n, input logic mw, input logic [31:0] a, input logic [31:0] wd,
                              input logic [2:0] t, input bit chk, input logic [31:0] exp);
    vec_t v;
    v.name = n; v.mw = mw; v.a = a; v.wd = wd; v.t = t; v.chk = chk; v.exp = exp;
    return v;
  endfunction

  // ---------------- test ----------------
  initial begin
    vec_t        vq [$];
    logic [31:0] c1;
    logic [31:0] c2;
    logic [7:0]  exp_bytes [$];

    vq.push_back(mk("sw_0x10",    1, 32'h10,    32'h1122_3344, 3'd0, 0, 32'h0));
    vq.push_back(mk("sb_0x11",    1, 32'h11,    32'h1234_56AA, 3'd3, 0, 32'h0));
    vq.push_back(mk("lw_0x10",    0, 32'h10,    32'h0,         3'd0, 1, 32'h1122_AA44));
    vq.push_back(mk("lh_0x12",    0, 32'h12,    32'h0,         3'd1, 1, 32'h0000_1122));
    vq.push_back(mk("lhu_0x12",   0, 32'h12,    32'h0,         3'd2, 1, 32'h0000_1122));
    vq.push_back(mk("sh_0x12",    1, 32'h12,    32'hFFFF_8001, 3'd1, 0, 32'h0));
    vq.push_back(mk("lh_0x12b",   0, 32'h12,    32'h0,         3'd1, 1, 32'hFFFF_8001));
    vq.push_back(mk("lhu_0x12b",  0, 32'h12,    32'h0,         3'd2, 1, 32'h0000_8001));
    vq.push_back(mk("lb_0x11",    0, 32'h11,    32'h0,         3'd3, 1, 32'hFFFF_FFAA));
    vq.push_back(mk("lbu_0x11",   0, 32'h11,    32'h0,         3'd4, 1, 32'h0000_00AA));
    vq.push_back(mk("lb_0x13",    0, 32'h13,    32'h0,         3'd3, 1, 32'hFFFF_FF80));
    vq.push_back(mk("alias_lw",   0, 32'h1010,  32'h0,         3'd0, 1, 32'h8001_AA44));
    vq.push_back(mk("sw_top",     1, 32'hFFC,   32'hCAFE_F00D, 3'd0, 0, 32'h0));
    vq.push_back(mk("lw_t7_top",  0, 32'hFFC,   32'h0,         3'd7, 1, 32'hCAFE_F00D));
    vq.push_back(mk("led_wr",     1, MB,        32'hFFFF_1234, 3'd0, 0, 32'h0));
    vq.push_back(mk("led_rd",     0, MB,        32'h0,         3'd0, 1, 32'h0000_1234));
    vq.push_back(mk("lh_led",     0, MB,        32'h0,         3'd1, 1, 32'h0));
    vq.push_back(mk("tx_rd",      0, MB + 12,   32'h0,         3'd0, 1, 32'h0));
    vq.push_back(mk("mmio_other", 0, MB + 32,   32'h0,         3'd0, 1, 32'h0));

    rst = 1'b1; tx_ready = 1'b0; sw = 16'h0;
    put(0, 32'h0, 32'h0, 3'd0);
    step(); step();
    rst = 1'b0;

    // reset state
    check("rst_led",      {16'h0, led},     32'h0);
    check("rst_misalign", {31'h0, misalign}, 32'h0);
    check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_tx_data",  {24'h0, tx_data},  32'h0);
    put(0, MB + 8, 32'h0, 3'd0);
    check("rst_cycle", rdata, 32'h0);
    put(0, MB + 16, 32'h0, 3'd0);
    check("rst_status", rdata, 32'h100);
    step();

    // table vectors
    foreach (vq[i]) begin
      put(vq[i].mw, vq[i].a, vq[i].wd, vq[i].t);
      if (vq[i].chk) check(vq[i].name, rdata, vq[i].exp);
      step();
    end
    check("led_out", {16'h0, led}, 32'h0000_1234);

    // misaligned accesses
    put(0, 32'h13, 32'h0, 3'd0);
    check("mis_lw_rdata", rdata, 32'h0);
    check("mis_before", {31'h0, misalign}, 32'h0);
    step();
    check("mis_set", {31'h0, misalign}, 32'h1);
    put(1, 32'h12, 32'hDEAD_BEEF, 3'd0);
    step();
    put(0, 32'h10, 32'h0, 3'd0);
    check("mis_sw_suppressed", rdata, 32'h8001_AA44);
    step();
    put(0, MB + 16, 32'h0, 3'd0);
    check("status_mis", rdata, 32'h500);
    step();
    put(1, MB + 16, 32'h400, 3'd0);
    step();
    check("mis_cleared", {31'h0, misalign}, 32'h0);
    put(1, MB + 18, 32'h400, 3'd0);
    step();
    check("mis_set_wins", {31'h0, misalign}, 32'h1);
    put(1, MB + 16, 32'h400, 3'd0);
    step();
    check("mis_cleared2", {31'h0, misalign}, 32'h0);

    // SW and CYCLE
    sw = 16'hBEEF;
    put(0, MB + 4, 32'h0, 3'd0);
    check("sw_read", rdata, 32'h0000_BEEF);
    step();
    put(0, MB + 8, 32'h0, 3'd0);
    c1 = rdata;
    check("cycle_abs", c1, m_cycle);
    repeat (7) step();
    c2 = rdata;
    check("cycle_delta", c2 - c1, 32'd7);

`ifdef DMEM_TXFIFO_EN
    // fill to full with handshake held off
    tx_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      put(1, MB + 12, 32'(i), 3'd0);
      step();
    end
    put(0, MB + 16, 32'h0, 3'd0);
    check("fifo_full_status", rdata, 32'h208);
    check("fifo_full_valid", {31'h0, tx_valid}, 32'h1);
    check("fifo_full_head", {24'h0, tx_data}, 32'h1);
    tx_ready = 1'b1;
    put(0, 32'h10, 32'h0, 3'd0);
    for (int i = 1; i <= 8; i++) begin
      check("drain_valid", {31'h0, tx_valid}, 32'h1);
      check("drain_data", {24'h0, tx_data}, 32'(i));
      step();
    end
    tx_ready = 1'b0;
    put(0, MB + 16, 32'h0, 3'd0);
    check("drain_empty_status", rdata, 32'h100);
    check("drain_empty_valid", {31'h0, tx_valid}, 32'h0);
    step();

    // push into a full FIFO while it pops
    for (int i = 0; i < 8; i++) begin
      put(1, MB + 12, 32'h10 + 32'(i), 3'd0);
      step();
    end
    tx_ready = 1'b1;
    put(1, MB + 12, 32'h5A, 3'd0);
    check("fullpop_head", {24'h0, tx_data}, 32'h10);
    step();
    put(0, MB + 16, 32'h0, 3'd0);
    check("fullpop_count", rdata, 32'h208);
    put(0, 32'h10, 32'h0, 3'd0);
    for (int i = 1; i < 8; i++) exp_bytes.push_back(8'h10 + 8'(i));
    exp_bytes.push_back(8'h5A);
    foreach (exp_bytes[k]) begin
      check("fullpop_data", {24'h0, tx_data}, {24'h0, exp_bytes[k]});
      step();
    end
    check("fullpop_done", {31'h0, tx_valid}, 32'h0);
`else
    tx_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      put(1, MB + 12, 32'(i), 3'd0);
      step();
      check("nofifo_valid", {31'h0, tx_valid}, 32'h0);
      check("nofifo_data", {24'h0, tx_data}, 32'h0);
    end
    put(0, MB + 16, 32'h0, 3'd0);
    check("nofifo_status", rdata, 32'h100);
    step();
`endif

    // reset mid-operation
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      put(1, MB + 12, 32'hA1 + 32'(i), 3'd0);
      step();
    end
    put(1, MB, 32'h0000_FFFF, 3'd0);
    step();
    put(0, 32'h13, 32'h0, 3'd0);
    step();
    check("pre_rst_led", {16'h0, led}, 32'h0000_FFFF);
    check("pre_rst_mis", {31'h0, misalign}, 32'h1);
    check("pre_rst_valid", {31'h0, tx_valid}, 32'(m_q.size() != 0));
    rst = 1'b1;
    put(1, 32'h10, 32'h0BAD_BAD0, 3'd0);
    step();
    rst = 1'b0;
    put(0, MB + 8, 32'h0, 3'd0);
    check("post_rst_valid", {31'h0, tx_valid}, 32'h0);
    check("post_rst_data", {24'h0, tx_data}, 32'h0);
    check("post_rst_led", {16'h0, led}, 32'h0);
    check("post_rst_mis", {31'h0, misalign}, 32'h0);
    check("post_rst_cycle", rdata, 32'h0);
    step();
    put(0, 32'h10, 32'h0, 3'd0);
    check("post_rst_ram_kept", rdata, 32'h8001_AA44);
    step();

    // randomized traffic against the model
    for (int w = 0; w < 64; w++) begin
      put(1, 32'(w * 4), $urandom, 3'd0);
      step();
    end
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a;
      logic [2:0]  t;
      logic        mw;
      int          r;
      r        = $urandom_range(0, 9);
      tx_ready = 1'($urandom_range(0, 1));
      sw       = 16'($urandom);
      if (r < 6) begin
        a  = 32'($urandom_range(0, 255));
        t  = 3'($urandom_range(0, 7));
        mw = ($urandom_range(0, 2) == 0);
      end else begin
        if ($urandom_range(0, 3) == 0) a = MB + 32'($urandom_range(0, 63));
        else                           a = MB + 32'($urandom_range(0, 5) * 4);
        t  = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
        mw = 1'($urandom_range(0, 1));
      end
      put(mw, a, $urandom, t);
      cmp_model();
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_unit.md
# dmem_unit

Data-memory stage endpoint for the 5-stage RISC-V core. It sits directly downstream of the core's EX/MEM register and consumes the core's `Addr_out`, `Data_out`, `DMType` and `mem_w` outputs. It returns load data, already aligned and extended, on the core's `Data_in`, in the same cycle, so MEM/WB latches it. Besides word-addressed RAM, it decodes a small MMIO window holding LEDs, switches, a cycle counter, a TX FIFO with valid/ready drain, and a sticky misalignment flag.

## Interface
- `DEPTH_WORDS`, default 1024: RAM depth in 32-bit words; a power of two.
- `MMIO_BASE`, default 32'hFFFF_0000: base address of the MMIO window (64 bytes).
- `FIFO_DEPTH`, default 8: TX FIFO entries; a power of two, at least 2.
- `clk` in 1: clock. One clock domain only.
- `rst` in 1: synchronous, active-high reset.
- `mem_w` in 1: store strobe from EX/MEM.
- `addr` in 32: byte address, taken from the core's `Addr_out`.
- `wdata` in 32: store data, taken from the core's `Data_out`; the operand is in its low bytes.
- `dm_type` in 3: access width. 000 word, 001 half, 010 half unsigned, 011 byte, 100 byte unsigned.
- `rdata` out 32: load result, driven to the core's `Data_in`.
- `sw` in 16: switch inputs.
- `led` out 16: LED register.
- `tx_data` out 8: FIFO head byte.
- `tx_valid` out 1: FIFO non-empty.
- `tx_ready` in 1: consumer accepts the head byte.
- `misalign` out 1: sticky misaligned-access flag.

## Operation
- **Region select:** an address is MMIO when `addr[31:6] == MMIO_BASE[31:6]`. Every other address is RAM, indexed by `addr[log2(DEPTH_WORDS)+1:2]`; upper bits are ignored.
- **RAM reads:** asynchronous.
  - Byte lane is `addr[1:0]`; halfword lane is `addr[1]`.
  - Signed types sign-extend; unsigned types zero-extend.
- **RAM writes:** take effect at the clock edge when `mem_w` is high, with a byte mask.
  - Word: mask 1111.
  - Half: mask 0011 or 1100, lane data `wdata[15:0]`.
  - Byte: one-hot mask, lane data `wdata[7:0]`.
- **Misalignment:** an access is misaligned when it is a word with `addr[1:0] != 0`, or a half with `addr[0] = 1`.
  - A misaligned access sets `misalign`.
  - A misaligned store is suppressed.
  - A misaligned load returns 0.
  - `dm_type` 101–111 is treated as word.
- **MMIO registers:** word access only. Non-word MMIO accesses are ignored, and reads of them return 0.
  - +0x00 LED: read/write, low 16 bits.
  - +0x04 SW: read-only, zero-extended `sw`.
  - +0x08 CYCLE: read-only free-running 32-bit counter; increments every cycle and wraps at 2^32.
  - +0x0C TX: write-only. A store pushes `wdata[7:0]`. Reads return 0.
  - +0x10 STATUS, read layout:
    - bits [7:0]: FIFO count.
    - bit 8: empty.
    - bit 9: full.
    - bit 10: misalign.
  - STATUS write: writing 1 to bit 10 clears `misalign`. If a new misaligned access occurs in the same cycle, the set wins.
  - Other offsets read 0; writes to them are ignored.
- **TX FIFO:**
  - A push occurs on an accepted TX store.
  - A pop occurs when `tx_valid && tx_ready`.
  - A push while full is dropped, unless a pop happens in the same cycle; then the push is accepted.
  - A simultaneous push and pop when empty is impossible, because a pop requires `tx_valid`.
  - Pointers wrap modulo `FIFO_DEPTH`.

## Timing
- `rdata` is combinational from `addr`, `dm_type` and current state, within the same cycle.
- Stores commit at the edge where `mem_w` is high. A load in the next cycle observes the new value; no same-cycle bypass.
- CYCLE reads the value held before the current edge.
- A TX push at edge N gives `tx_valid = 1` and `tx_data` equal to the pushed byte from cycle N+1.
- A pop at edge N advances `tx_data` in cycle N+1.
- Reset values:
  - `led` = 0, CYCLE = 0, FIFO pointers/count = 0.
  - `tx_valid` = 0, `tx_data` = 0, `misalign` = 0.
  - `rdata` follows the reset state combinationally.
  - RAM contents are not reset.
- Reset asserted mid-operation discards FIFO contents and any store in that cycle. No RAM or MMIO write occurs during a reset cycle.

## Configuration
- `DMEM_TXFIFO_EN` defined: TX FIFO built as described.
- `DMEM_TXFIFO_EN` undefined:
  - No FIFO storage.
  - TX stores are ignored.
  - `tx_valid` and `tx_data` are tied to 0; `tx_ready` is unused.
  - STATUS reads count 0, empty 1, full 0.

## Test plan
- **RAM byte/half stores and loads:**
  - Stimulus: sw 0x11223344 @0x10; sb 0xAA @0x11; then load @0x10, then lh @0x12, then lhu @0x12.
  - Required: lw returns 0x1122AA44; lh @0x12 returns 0x00001122; after sh 0x8001 @0x12, lh returns 0xFFFF8001 and lhu returns 0x00008001.
- **Misaligned accesses:**
  - Stimulus: lw @0x13, then sw @0x12.
  - Required: `misalign` rises; the store leaves RAM unchanged; the load returns 0.
  - Then: STATUS write 0x400 clears it; a concurrent misaligned access keeps it set.
- **MMIO registers:**
  - LED write 0x1234: `led` = 0x1234 next cycle; readback 0x00001234.
  - `sw` = 0xBEEF: SW reads 0x0000BEEF.
  - Two CYCLE reads k cycles apart differ by k.
- **FIFO full and handshake:**
  - With `tx_ready` = 0, push bytes 1..9: count saturates at 8, full = 1, byte 9 dropped.
  - Raise `tx_ready`: bytes 1..8 emerge in order, one per cycle; then empty = 1 and `tx_valid` = 0.
- **Full-FIFO push with pop:**
  - With FIFO full and `tx_ready` = 1, push 0x5A.
  - Required: count stays 8; 0x5A is drained last.
- **Reset mid-operation:**
  - Assert `rst` with 3 bytes queued and `led` = 0xFFFF.
  - Required next cycle: `tx_valid` = 0, `led` = 0, CYCLE = 0; RAM word @0x10 retained.
